// File: rtl/mac_window_array.sv
// Multi-lane windowed multiply-accumulate engine: per-lane (a*b)>>PROD_SHIFT products
// are summed over a programmable number of beats and emitted on a valid/ready stream.
module mac_window_array #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int PROD_SHIFT = 8,
  parameter int ACC_W      = 12,
  parameter int OUT_W      = 8,
  parameter int LEN_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   sat_en,
  input  logic [LEN_W-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*DATA_W-1:0] a_in,
  input  logic [LANES*DATA_W-1:0] b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   busy
);

  localparam int PROD_W = 2*DATA_W - PROD_SHIFT;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic             flush;
  logic             load_out;
  logic [LEN_W-1:0] len_eff;

  assign len_eff = (len == '0) ? LEN_W'(1) : len;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    s1_valid_d  = 1'b0;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    flush       = 1'b0;
    load_out    = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
      flush       = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            len_d      = len_eff;
            count_d    = LEN_W'(1);
            s1_valid_d = 1'b1;
            state_d    = (len_eff == LEN_W'(1)) ? DRAIN : ACC;
          end
        end
        ACC: begin
          in_ready = 1'b1;
          if (in_valid) begin
            count_d    = count_q + LEN_W'(1);
            s1_valid_d = 1'b1;
            if (count_d == len_q) state_d = DRAIN;
          end
        end
        // The final product is being added this cycle; capture the result alongside it.
        DRAIN: begin
          load_out    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            flush       = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0]   a_l, b_l;
      logic [2*DATA_W-1:0] full_prod;
      logic [PROD_W-1:0]   prod_shifted;
      logic [PROD_W-1:0]   prod_q, prod_d;
      logic [ACC_W-1:0]    acc_q, acc_d, acc_upd;
      logic [ACC_W:0]      sum;
      logic [OUT_W-1:0]    res_q, res_d;

      assign a_l          = a_in[gi*DATA_W +: DATA_W];
      assign b_l          = b_in[gi*DATA_W +: DATA_W];
      assign full_prod    = {{DATA_W{1'b0}}, a_l} * {{DATA_W{1'b0}}, b_l};
      assign prod_shifted = PROD_W'(full_prod >> PROD_SHIFT);
      // One extra carry bit tells saturation apart from wrap.
      assign sum          = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
      assign acc_upd      = (sat_en && sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

      always_comb begin
        prod_d = s1_valid_d ? prod_shifted : prod_q;
        acc_d  = acc_q;
        if (flush)           acc_d = '0;
        else if (s1_valid_q) acc_d = acc_upd;
        res_d  = load_out ? acc_upd[ACC_W-1 -: OUT_W] : res_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prod_q <= '0;
          acc_q  <= '0;
          res_q  <= '0;
        end else begin
          prod_q <= prod_d;
          acc_q  <= acc_d;
          res_q  <= res_d;
        end
      end

      assign out_data[gi*OUT_W +: OUT_W] = res_q;
    end
  endgenerate

endmodule

// File: tb/tb_mac_window_array.sv
// Randomised scoreboard bench for mac_window_array: a plain-arithmetic window model
// queues expected results, a monitor checks them as the DUT presents them.
module tb_mac_window_array;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int OW    = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic                  sat_en;
  logic [LW-1:0]         len;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   a_in;
  logic [LANES*DW-1:0]   b_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OW-1:0]   out_data;
  logic                  busy;

  mac_window_array dut (
    .clk(clk), .rst(rst), .clear(clear), .sat_en(sat_en), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      $display("ok   %s value=%0h (cycle %0d)", nm, act, cyc);
    end
  endtask

  typedef struct {
    logic [LANES*OW-1:0] data;
    int                  cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference window model: plain integer arithmetic per lane.
  int m_acc[LANES];
  int m_beats = 0;
  int m_len   = 0;

  function automatic void model_reset();
    for (int i = 0; i < LANES; i++) m_acc[i] = 0;
    m_beats = 0;
  endfunction

  function automatic void model_beat(input logic [31:0] a, input logic [31:0] b,
                                     input logic [7:0] l, input bit sat, input int edge_cyc);
    exp_t e;
    if (m_beats == 0) m_len = (l == 0) ? 1 : int'(l);
    for (int i = 0; i < LANES; i++) begin
      int p, s;
      p = (int'((a >> (8*i)) & 32'hFF) * int'((b >> (8*i)) & 32'hFF)) / 256;
      s = m_acc[i] + p;
      m_acc[i] = sat ? ((s > 4095) ? 4095 : s) : (s % 4096);
    end
    m_beats++;
    if (m_beats == m_len) begin
      e.data = '0;
      for (int i = 0; i < LANES; i++) e.data[i*OW +: OW] = 8'(m_acc[i] / 16);
      e.cyc = edge_cyc + 1;
      exp_q.push_back(e);
      model_reset();
    end
  endfunction

  // out_ready driver: random or forced.
  bit rr_mode   = 1'b0;
  bit force_rdy = 1'b1;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rr_mode ? 1'($urandom_range(0, 1)) : force_rdy;
    end
  end

  // Monitor: pops on each new result, checks hold behaviour while stalled.
  initial begin
    bit                  prev;
    logic [LANES*OW-1:0] held;
    exp_t                e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", out_data, '0);
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=out_valid expected=no result");
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_latency", 64'(cyc), 64'(e.cyc));
          end
          held = out_data;
        end else if (out_valid && prev) begin
          check("hold_data", out_data, held);
          check("hold_in_ready", in_ready, 1'b0);
          check("hold_busy", busy, 1'b1);
        end
        prev = out_valid;
      end
    end
  end

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] l, output int waited);
    bit done;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    len = l;
    waited = -1;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        waited = t;
        done = 1'b1;
        model_beat(a, b, l, sat_en, cyc + 1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    len = 8'($urandom);
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic send_window(input logic [7:0] l, input bit rnd,
                             input logic [31:0] a, input logic [31:0] b, input bit gaps);
    int nb, w;
    logic [31:0] aa, bb;
    nb = (l == 0) ? 1 : int'(l);
    for (int i = 0; i < nb; i++) begin
      aa = rnd ? $urandom : a;
      bb = rnd ? $urandom : b;
      send_beat(aa, bb, l, w);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    if (!done) check("out_valid_timeout", 0, 1);
  endtask

  task automatic reset_checks(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int w;
    rst = 1'b0; clear = 1'b0; sat_en = 1'b0; len = '0;
    in_valid = 1'b0; a_in = '0; b_in = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // All lanes 255*255, len 4, wrap.
    send_window(8'd4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();

    // len 20, wrap then saturate.
    sat_en = 1'b0;
    send_window(8'd20, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    sat_en = 1'b1;
    send_window(8'd20, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    sat_en = 1'b0;

    // Distinct lanes, len 0 acts as a single beat.
    send_window(8'd0, 1'b0, 32'h0000_1080, 32'h0000_1080, 1'b0);
    wait_idle();

    // Backpressure, then handshake with a beat already waiting.
    force_rdy = 1'b0;
    send_window(8'd2, 1'b1, 32'h0, 32'h0, 1'b0);
    wait_out_valid();
    repeat (5) @(negedge clk);
    force_rdy = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a_in = 32'h0102_0304;
    b_in = 32'hFFFF_FFFF;
    len = 8'd1;
    @(negedge clk);
    check("hs_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    send_beat(32'h0102_0304, 32'hFFFF_FFFF, 8'd1, w);
    check("accept_after_hs", 64'(w), 64'd0);
    wait_idle();

    // Clear after two of four beats.
    send_beat($urandom, $urandom, 8'd4, w);
    send_beat($urandom, $urandom, 8'd4, w);
    clear = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("clear_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check("clear_busy", busy, 1'b0);
    send_window(8'd4, 1'b1, 32'h0, 32'h0, 1'b1);
    wait_idle();

    // Random windows with random backpressure.
    rr_mode = 1'b1;
    for (int k = 0; k < 25; k++) begin
      sat_en = 1'($urandom_range(0, 1));
      send_window(8'($urandom_range(0, 7)), 1'b1, 32'h0, 32'h0, 1'($urandom_range(0, 1)));
      wait_idle();
    end
    rr_mode = 1'b0;
    force_rdy = 1'b1;
    sat_en = 1'b0;
    @(posedge clk); #1;

    // Reset mid-window.
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd4, w);
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd4, w);
    reset_checks("rst_mid");

    // Reset while a result is pending.
    force_rdy = 1'b0;
    send_window(8'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_out_valid();
    @(posedge clk); #1;
    reset_checks("rst_out");
    force_rdy = 1'b1;
    @(posedge clk); #1;

    // Clean window after reset.
    send_window(8'd4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
